// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: channel codes, framing FSM states and default word width shared by the I2S blocks.
package i2s_rx_pkg;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;
    localparam int   DW_DEF   = 16;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_SYNC,
        ST_RUN
    } state_e;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// i2s_rx_sync_edge: multi-stage synchronizer for a strobe plus W data bits, with rise detect on the strobe.
// Data bits ride in the same chain as the strobe so they stay aligned with its detected edge.
module i2s_rx_sync_edge #(
    parameter int W      = 2,
    parameter int STAGES = 2
) (
    input  logic         mclk,
    input  logic         rst_n,
    input  logic         strobe_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] d_o,
    output logic         rise_o
);

    logic [STAGES-1:0][W:0] chain_q, chain_d;
    logic                   prev_q, prev_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], {d_i, strobe_i}};
        prev_d  = chain_q[STAGES-1][0];
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign d_o    = chain_q[STAGES-1][W:1];
    assign rise_o = chain_q[STAGES-1][0] & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver; recovers left/right PCM words from sclk/lrclk/sdata oversampled by mclk.
// Locks after two word-select boundaries and drops lock when sclk stalls for TIMEOUT mclk cycles.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024,
    parameter int SLOT_MAX    = 64
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic          sclk_i,
    input  logic          lrclk_i,
    input  logic          sdata_i,
    output logic [DW-1:0] l_dout,
    output logic [DW-1:0] r_dout,
    output logic          l_valid,
    output logic          r_valid,
    output logic          locked,
    output logic          err_short
);

    localparam int CW = $clog2(SLOT_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    sd;
    logic          sclk_rise;
    state_e        state_q, state_d;
    logic          ws_d_q, ws_d_d, ch_q, ch_d;
    logic [DW-1:0] shift_q, shift_d, l_dout_q, l_dout_d, r_dout_q, r_dout_d, word;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          l_valid_q, l_valid_d, r_valid_q, r_valid_d;
    logic          locked_q, locked_d, err_short_q, err_short_d;
    logic          short, boundary, timeout, deliver;

    i2s_rx_sync_edge #(.W(2), .STAGES(SYNC_STAGES)) u_sync (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .strobe_i (sclk_i),
        .d_i      ({lrclk_i, sdata_i}),
        .d_o      (sd),
        .rise_o   (sclk_rise)
    );

    always_comb begin
        short       = bit_cnt_q < CW'(DW);
        word        = short ? shift_q << (CW'(DW) - bit_cnt_q) : shift_q;
        boundary    = ws_d_q != ch_q;
        timeout     = to_cnt_q == TW'(TIMEOUT - 1);
        deliver     = !timeout && sclk_rise && boundary && state_q == ST_RUN;
        state_d     = state_q;
        ws_d_d      = ws_d_q;
        ch_d        = ch_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = sclk_rise ? '0 : to_cnt_q + 1'b1;
        l_dout_d    = (deliver && ch_q == CH_LEFT) ? word : l_dout_q;
        r_dout_d    = (deliver && ch_q == CH_RIGHT) ? word : r_dout_q;
        l_valid_d   = deliver && ch_q == CH_LEFT;
        r_valid_d   = deliver && ch_q == CH_RIGHT;
        err_short_d = deliver && short;
        if (timeout) begin
            state_d   = ST_UNLOCKED;
            shift_d   = '0;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
        end else if (sclk_rise) begin
            // the bit sampled now belongs to the word-select seen one sclk earlier
            ws_d_d = sd[1];
            ch_d   = ws_d_q;
            if (boundary) begin
                state_d   = (state_q == ST_UNLOCKED) ? ST_SYNC : ST_RUN;
                shift_d   = {{(DW-1){1'b0}}, sd[0]};
                bit_cnt_d = CW'(1);
            end else begin
                if (short) shift_d = {shift_q[DW-2:0], sd[0]};
                if (bit_cnt_q != CW'(SLOT_MAX)) bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
        locked_d = state_d == ST_RUN;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNLOCKED;
            ws_d_q      <= 1'b0;
            ch_q        <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            l_dout_q    <= '0;
            r_dout_q    <= '0;
            l_valid_q   <= 1'b0;
            r_valid_q   <= 1'b0;
            locked_q    <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ws_d_q      <= ws_d_d;
            ch_q        <= ch_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            l_dout_q    <= l_dout_d;
            r_dout_q    <= r_dout_d;
            l_valid_q   <= l_valid_d;
            r_valid_q   <= r_valid_d;
            locked_q    <= locked_d;
            err_short_q <= err_short_d;
        end
    end

    assign l_dout    = l_dout_q;
    assign r_dout    = r_dout_q;
    assign l_valid   = l_valid_q;
    assign r_valid   = r_valid_q;
    assign locked    = locked_q;
    assign err_short = err_short_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: drives I2S frames into i2s_rx and checks delivered words against a framing scoreboard.
module tb_i2s_rx;

    localparam int DW = 16;
    localparam int TO = 1024;

    logic          mclk = 1'b0, rst_n = 1'b1, sclk = 1'b0, lrclk = 1'b0, sdata = 1'b0;
    logic [DW-1:0] l_dout, r_dout;
    logic          l_valid, r_valid, locked, err_short;

    typedef struct packed {
        logic          ch;
        logic [DW-1:0] w;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            vectors = 0, miscompares = 0, deliveries = 0, errs_seen = 0;
    int            div = 8, jit = 0;
    logic          m_prev = 1'b0, m_ch = 1'b0;
    int            m_nb = 0, m_cnt = 0;
    logic [DW-1:0] m_w = '0;

    always #5 mclk = ~mclk;

    i2s_rx #(.DW(DW), .SYNC_STAGES(2), .TIMEOUT(TO), .SLOT_MAX(64)) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .sclk_i    (sclk),
        .lrclk_i   (lrclk),
        .sdata_i   (sdata),
        .l_dout    (l_dout),
        .r_dout    (r_dout),
        .l_valid   (l_valid),
        .r_valid   (r_valid),
        .locked    (locked),
        .err_short (err_short)
    );

    // Reference framing: a word closes when the channel owning the current bit changes.
    task automatic sclk_cycle(input logic ws, input logic b);
        logic cur;
        cur = m_prev;
        if (cur != m_ch) begin
            if (m_nb >= 2) sb.push_back(exp_t'{m_ch, m_w, m_cnt < DW});
            m_nb++;
            m_cnt = 0;
            m_w = '0;
        end
        if (m_cnt < DW) m_w[DW-1-m_cnt] = b;
        m_cnt++;
        m_ch = cur;
        m_prev = ws;
        sclk = 1'b0;
        lrclk = ws;
        sdata = b;
        #(div * 5 + int'($urandom_range(0, jit)));
        sclk = 1'b1;
        #(div * 5 + int'($urandom_range(0, jit)));
    endtask

    task automatic send_slot(input logic ch, input logic nxt, input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++)
            sclk_cycle((i == n - 1) ? nxt : ch, (i < DW) ? w[DW-1-i] : 1'b0);
    endtask

    task automatic send_frames(input int nf, input int n, input logic [DW-1:0] lw, input logic [DW-1:0] rw);
        for (int f = 0; f < nf; f++) begin
            send_slot(1'b0, 1'b1, lw, n);
            send_slot(1'b1, 1'b0, rw, n);
        end
    endtask

    task automatic tail_and_drain(input string name);
        send_slot(1'b0, 1'b0, '0, 4);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge mclk);
        repeat (5) @(negedge mclk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d words still expected, required 0", name, sb.size());
        end
    endtask

    task automatic idle_timeout();
        repeat (TO + 20) @(posedge mclk);
        m_nb = 0;
        m_cnt = 0;
        m_w = '0;
    endtask

    task automatic model_reset();
        m_prev = 1'b0;
        m_ch = 1'b0;
        m_nb = 0;
        m_cnt = 0;
        m_w = '0;
        sb.delete();
    endtask

    task automatic check_count(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic monitor();
        exp_t          e;
        logic [DW-1:0] got, pl, pr;
        pl = '0;
        pr = '0;
        forever begin
            @(negedge mclk);
            if (!rst_n) begin
                pl = '0;
                pr = '0;
                continue;
            end
            if (l_valid && r_valid) begin
                vectors++;
                miscompares++;
                $display("FAIL both_valid: l_valid=1 r_valid=1, required at most one");
            end
            if ((!l_valid && l_dout !== pl) || (!r_valid && r_dout !== pr)) begin
                miscompares++;
                $display("FAIL dout_hold: l=%h r=%h changed without valid, required l=%h r=%h", l_dout, r_dout, pl, pr);
            end
            if (l_valid || r_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_valid: ch=%0d data=%h, required no valid", r_valid, r_valid ? r_dout : l_dout);
                end else begin
                    e = sb.pop_front();
                    deliveries++;
                    got = r_valid ? r_dout : l_dout;
                    if ({r_valid, got, err_short} !== {e.ch, e.w, e.err}) begin
                        miscompares++;
                        $display("FAIL word: ch=%0d data=%h err=%0d, required ch=%0d data=%h err=%0d",
                                 r_valid, got, err_short, e.ch, e.w, e.err);
                    end
                end
            end else if (err_short) begin
                vectors++;
                miscompares++;
                $display("FAIL err_alone: err_short=1 without valid, required 0");
            end
            if (err_short) errs_seen++;
            pl = l_dout;
            pr = r_dout;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge mclk);
        check_word("reset_l_dout", l_dout, '0);
        check_word("reset_r_dout", r_dout, '0);
        check_count("reset_flags", {l_valid, r_valid, locked, err_short}, 0);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge mclk);
    endtask

    task automatic test_basic_32();
        int d0, e0;
        d0 = deliveries;
        e0 = errs_seen;
        send_frames(3, 32, 16'hA5C3, 16'h5A3C);
        tail_and_drain("basic32");
        check_count("basic32_deliveries", deliveries - d0, 4);
        check_count("basic32_err", errs_seen - e0, 0);
        check_word("basic32_l", l_dout, 16'hA5C3);
        check_word("basic32_r", r_dout, 16'h5A3C);
        check_count("basic32_locked", int'(locked), 1);
    endtask

    task automatic test_exact_16();
        int d0, e0;
        idle_timeout();
        d0 = deliveries;
        e0 = errs_seen;
        send_frames(3, 16, 16'h8001, 16'h7FFE);
        tail_and_drain("exact16");
        check_count("exact16_deliveries", deliveries - d0, 4);
        check_count("exact16_err", errs_seen - e0, 0);
        check_word("exact16_l", l_dout, 16'h8001);
        check_word("exact16_r", r_dout, 16'h7FFE);
    endtask

    task automatic test_short_slot();
        int d0, e0;
        idle_timeout();
        d0 = deliveries;
        e0 = errs_seen;
        send_frames(2, 32, 16'h1234, 16'h4321);
        send_slot(1'b0, 1'b1, 16'hFFF0, 12);
        send_slot(1'b1, 1'b0, 16'hABCD, 32);
        tail_and_drain("short");
        check_count("short_deliveries", deliveries - d0, 4);
        check_count("short_err", errs_seen - e0, 1);
        check_word("short_l", l_dout, 16'hFFF0);
        check_word("short_r", r_dout, 16'hABCD);
    endtask

    task automatic test_timeout();
        int d0;
        idle_timeout();
        d0 = deliveries;
        send_frames(1, 32, 16'h1111, 16'h2222);
        send_slot(1'b0, 1'b1, 16'h3333, 32);
        send_slot(1'b1, 1'b1, 16'h4444, 10);
        repeat (20) @(negedge mclk);
        check_count("timeout_pre_deliveries", deliveries - d0, 1);
        check_count("timeout_locked_before", int'(locked), 1);
        idle_timeout();
        @(negedge mclk);
        check_count("timeout_locked_after", int'(locked), 0);
        check_count("timeout_no_valid", deliveries - d0, 1);
        send_frames(2, 32, 16'h5555, 16'h6666);
        tail_and_drain("timeout");
        check_count("timeout_post_deliveries", deliveries - d0, 4);
        check_word("timeout_r", r_dout, 16'h6666);
    endtask

    task automatic test_mid_reset();
        int d0;
        idle_timeout();
        send_frames(2, 32, 16'hC0DE, 16'hBEEF);
        send_slot(1'b0, 1'b0, 16'hDEAD, 8);
        rst_n = 1'b0;
        #1;
        check_word("midrst_l_dout", l_dout, '0);
        check_word("midrst_r_dout", r_dout, '0);
        check_count("midrst_flags", {l_valid, r_valid, locked, err_short}, 0);
        repeat (4) @(negedge mclk);
        model_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge mclk);
        d0 = deliveries;
        send_frames(3, 32, 16'h0F0F, 16'hF00F);
        tail_and_drain("midrst");
        check_count("midrst_deliveries", deliveries - d0, 4);
        check_word("midrst_l", l_dout, 16'h0F0F);
        check_word("midrst_r", r_dout, 16'hF00F);
    endtask

    task automatic test_phase_sweep();
        int divs[4] = '{4, 6, 8, 4};
        int jits[4] = '{0, 3, 9, 4};
        int d0, e0, n;
        for (int s = 0; s < 4; s++) begin
            idle_timeout();
            div = divs[s];
            jit = jits[s];
            d0 = deliveries;
            e0 = errs_seen;
            for (int f = 0; f < 40; f++) begin
                n = DW + int'($urandom_range(0, 8));
                send_slot(1'b0, 1'b1, DW'($urandom), n);
                send_slot(1'b1, 1'b0, DW'($urandom), n);
            end
            tail_and_drain("sweep");
            check_count("sweep_deliveries", deliveries - d0, 78);
            check_count("sweep_err", errs_seen - e0, 0);
        end
        div = 8;
        jit = 0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic_32();
        test_exact_16();
        test_short_slot();
        test_timeout();
        test_mid_reset();
        test_phase_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
